pc_fetch_ctrl: RTL and testbench

Next-generation program counter and fetch-request generator for the IF stage. Holds the PC and drives an SRAM-like instruction port (req / addr_ok / data_ok), allowing one request in flight. Branch and exception redirects are accepted at any time. Redirects that arrive while a request is outstanding are buffered, and the affected fetch result is cancelled. An address error is raised for a misaligned PC.

---
 rtl/pc_fetch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// IF-stage PC holder and fetch requester, one request in flight; PC_DELAY_SLOT_EN keeps the instruction after a branch.
// Latency: pc_valid in the inst_data_ok cycle; next request one cycle later (one instruction per two cycles at best).
// Backpressure: stall gates only new requests; inst_req holds until inst_addr_ok; inst_data_ok is always taken.
module pc_fetch_ctrl #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'hBFC00000,
  parameter int unsigned      STEP      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] flush_pc,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  output logic [WIDTH-1:0] pc_out,
  output logic             pc_valid,
  output logic             adel
);

`ifdef PC_DELAY_SLOT_EN
  localparam bit DSLOT = 1'b1;
`else
  localparam bit DSLOT = 1'b0;
`endif

  typedef enum logic [1:0] {BOOT, REQ, WAIT, ERR} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] issued_q, issued_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic             pend_q, pend_d;
  logic             pend_flush_q, pend_flush_d;
  logic             cancel_q, cancel_d;
  logic             hold_q, hold_d;

  logic             redir;
  logic             redir_cancel;
  logic [WIDTH-1:0] redir_pc;
  logic             misaligned;

  // A buffered flush target is never displaced by a later branch.
  assign redir        = flush | (br_taken & ~(pend_q & pend_flush_q));
  assign redir_cancel = flush | (br_taken & ~DSLOT);
  assign redir_pc     = flush ? flush_pc : br_target;
  assign misaligned   = |pc_q[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    issued_d     = issued_q;
    pend_pc_d    = pend_pc_q;
    pend_d       = pend_q;
    pend_flush_d = pend_flush_q;
    cancel_d     = cancel_q;
    hold_d       = 1'b0;
    inst_req     = 1'b0;
    inst_addr    = pc_q;
    pc_out       = pc_q;
    pc_valid     = 1'b0;
    adel         = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = REQ;
        if (redir && redir_cancel) begin
          pc_d = redir_pc;
        end else if (redir) begin
          // delay slot: fetch current PC first, then the target
          pend_d       = 1'b1;
          pend_pc_d    = redir_pc;
          pend_flush_d = 1'b0;
        end
      end

      REQ: begin
        inst_req = (hold_q | ~stall) & ~misaligned;
        if (inst_req) begin
          hold_d = ~inst_addr_ok;
          if (redir) begin
            pend_d       = 1'b1;
            pend_pc_d    = redir_pc;
            pend_flush_d = flush;
            cancel_d     = cancel_q | redir_cancel;
          end
          if (inst_addr_ok) begin
            issued_d = pc_q;
            state_d  = WAIT;
          end
        end else if (redir && redir_cancel) begin
          pc_d         = redir_pc;
          pend_d       = 1'b0;
          pend_flush_d = 1'b0;
        end else if (redir) begin
          pend_d       = 1'b1;
          pend_pc_d    = redir_pc;
          pend_flush_d = 1'b0;
        end else if (!stall && misaligned) begin
          pc_valid = 1'b1;
          adel     = 1'b1;
          state_d  = ERR;
        end
      end

      WAIT: begin
        pc_out = issued_q;
        if (inst_data_ok) begin
          pc_valid = ~cancel_q & ~(redir & redir_cancel);
          if (redir)       pc_d = redir_pc;
          else if (pend_q) pc_d = pend_pc_q;
          else             pc_d = issued_q + WIDTH'(STEP);
          pend_d       = 1'b0;
          pend_flush_d = 1'b0;
          cancel_d     = 1'b0;
          state_d      = REQ;
        end else if (redir) begin
          pend_d       = 1'b1;
          pend_pc_d    = redir_pc;
          pend_flush_d = flush;
          cancel_d     = cancel_q | redir_cancel;
        end
      end

      ERR: begin
        if (flush) begin
          pc_d         = flush_pc;
          pend_d       = 1'b0;
          pend_flush_d = 1'b0;
          cancel_d     = 1'b0;
          state_d      = REQ;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VEC;
      issued_q     <= RESET_VEC;
      pend_pc_q    <= RESET_VEC;
      pend_q       <= 1'b0;
      pend_flush_q <= 1'b0;
      cancel_q     <= 1'b0;
      hold_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      issued_q     <= issued_d;
      pend_pc_q    <= pend_pc_d;
      pend_q       <= pend_d;
      pend_flush_q <= pend_flush_d;
      cancel_q     <= cancel_d;
      hold_q       <= hold_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        adel;

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .br_taken(br_taken), .br_target(br_target), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .pc_out(pc_out),
    .pc_valid(pc_valid), .adel(adel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the next PC to fetch, the one fetch in flight (if any) and whether its
  // result is dropped, and a saved redirect target applied when that fetch returns.
  bit          m_boot, m_err, m_fly, m_hold, m_drop, m_has_tgt, m_tgt_flush;
  logic [31:0] m_pc, m_fly_pc, m_tgt;

  logic [31:0] seen_issue[$];
  logic [31:0] seen_pc[$];
  bit          seen_adel[$];

  task automatic model_reset();
    m_boot = 1; m_err = 0; m_fly = 0; m_hold = 0; m_drop = 0; m_has_tgt = 0; m_tgt_flush = 0;
    m_pc = 32'hBFC0_0000; m_fly_pc = '0; m_tgt = '0;
  endtask

  task automatic save_target(input logic [31:0] t);
    m_has_tgt = 1; m_tgt = t; m_tgt_flush = flush; m_drop = 1;
  endtask

  // Called once per cycle at the falling edge, with this cycle's inputs applied.
  task automatic model_step();
    bit          redir, exp_req, exp_valid, exp_adel;
    logic [31:0] rtgt, exp_pcout;
    redir     = flush || (br_taken && !m_err && !(m_has_tgt && m_tgt_flush));
    rtgt      = flush ? flush_pc : br_target;
    exp_req   = 0;
    exp_valid = 0;
    exp_adel  = 0;
    exp_pcout = m_pc;

    if (inst_req && inst_addr_ok) seen_issue.push_back(inst_addr);
    if (pc_valid) begin seen_pc.push_back(pc_out); seen_adel.push_back(adel); end

    if (m_boot) begin
      if (redir) m_pc = rtgt;
      m_boot = 0;
    end else if (m_err) begin
      if (flush) begin m_pc = flush_pc; m_err = 0; end
    end else if (m_fly) begin
      exp_pcout = m_fly_pc;
      if (inst_data_ok) begin
        exp_valid = !m_drop && !redir;
        m_pc = redir ? rtgt : (m_has_tgt ? m_tgt : m_fly_pc + 32'd4);
        m_fly = 0; m_has_tgt = 0; m_tgt_flush = 0; m_drop = 0;
      end else if (redir) begin
        save_target(rtgt);
      end
    end else begin
      exp_req = (m_hold || !stall) && (m_pc[1:0] == 2'b00);
      if (exp_req) begin
        if (redir) save_target(rtgt);
        if (inst_addr_ok) begin m_fly = 1; m_fly_pc = m_pc; m_hold = 0; end
        else m_hold = 1;
      end else if (redir) begin
        m_pc = rtgt;
      end else if (!stall && m_pc[1:0] != 2'b00) begin
        exp_valid = 1; exp_adel = 1; m_err = 1;
      end
    end

    check_eq("inst_req", 32'(inst_req), 32'(exp_req));
    check_eq("pc_valid", 32'(pc_valid), 32'(exp_valid));
    check_eq("adel", 32'(adel), 32'(exp_adel));
    if (exp_req)   check_eq("inst_addr", inst_addr, m_hold ? m_pc : exp_pcout);
    if (exp_valid) check_eq("pc_out", pc_out, exp_pcout);
  endtask

  task automatic cyc(input bit s, input bit f, input logic [31:0] fp, input bit b,
                     input logic [31:0] bt, input bit aok, input bit dok);
    @(posedge clk); #1;
    stall = s; flush = f; flush_pc = fp; br_taken = b; br_target = bt;
    inst_addr_ok = aok; inst_data_ok = dok;
    @(negedge clk);
    model_step();
  endtask

  task automatic idle(input bit aok, input bit dok);
    cyc(0, 0, 32'h0, 0, 32'h0, aok, dok);
  endtask

  task automatic do_reset(input bit stale_dok);
    @(posedge clk); #1;
    rst_n = 0; stall = 0; flush = 0; br_taken = 0; inst_addr_ok = 0; inst_data_ok = stale_dok;
    #1;
    check_eq("rst_inst_req", 32'(inst_req), 32'd0);
    check_eq("rst_inst_addr", inst_addr, 32'hBFC0_0000);
    check_eq("rst_pc_out", pc_out, 32'hBFC0_0000);
    check_eq("rst_pc_valid", 32'(pc_valid), 32'd0);
    check_eq("rst_adel", 32'(adel), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    model_step();
  endtask

  task automatic clear_seen();
    seen_issue.delete(); seen_pc.delete(); seen_adel.delete();
  endtask

  function automatic logic [31:0] rand_tgt(input int mis_pct);
    logic [31:0] t;
    if ($urandom_range(0, 19) == 0) t = 32'hFFFF_FFFC;
    else t = 32'hBFC0_0000 | ($urandom & 32'h0000_0FFC);
    if ($urandom_range(0, 99) < mis_pct) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  initial begin
    bit s, f, b, a, d;
    model_reset();
    do_reset(0);

    // sequential fetch
    clear_seen();
    idle(1, 0); idle(0, 1); idle(0, 0); idle(1, 0); idle(0, 1); idle(1, 0); idle(0, 1);
    check_eq("seq_first_addr", seen_issue.size() > 0 ? seen_issue[0] : 32'hX, 32'hBFC0_0000);
    check_eq("seq_count", seen_pc.size(), 3);
    if (seen_pc.size() == 3) begin
      check_eq("seq_pc0", seen_pc[0], 32'hBFC0_0000);
      check_eq("seq_pc1", seen_pc[1], 32'hBFC0_0004);
      check_eq("seq_pc2", seen_pc[2], 32'hBFC0_0008);
    end

    // stall holds off the next request without skipping a PC
    clear_seen();
    repeat (3) cyc(1, 0, 32'h0, 0, 32'h0, 1, 0);
    idle(1, 0); idle(0, 1);
    check_eq("stall_addr", seen_issue.size() == 1 ? seen_issue[0] : 32'hX, 32'hBFC0_000C);
    check_eq("stall_pc", seen_pc.size() == 1 ? seen_pc[0] : 32'hX, 32'hBFC0_000C);

    // branch while waiting cancels the in-flight result
    clear_seen();
    idle(1, 0);
    cyc(0, 0, 32'h0, 1, 32'hBFC0_0100, 0, 0);
    idle(0, 1); idle(1, 0);
    check_eq("br_drop", seen_pc.size(), 0);
    check_eq("br_next_addr", seen_issue.size() == 2 ? seen_issue[1] : 32'hX, 32'hBFC0_0100);
    idle(0, 1);

    // flush beats a same-cycle branch and a later branch
    clear_seen();
    idle(1, 0);
    cyc(0, 1, 32'hBFC0_0380, 1, 32'hBFC0_0200, 0, 0);
    cyc(0, 0, 32'h0, 1, 32'hBFC0_0300, 0, 0);
    idle(0, 1); idle(1, 0);
    check_eq("fl_next_addr", seen_issue.size() == 2 ? seen_issue[1] : 32'hX, 32'hBFC0_0380);
    check_eq("fl_drop", seen_pc.size(), 0);
    idle(0, 1);

    // misaligned flush target raises adel and parks until the next flush
    clear_seen();
    cyc(1, 1, 32'hBFC0_0382, 0, 32'h0, 0, 0);
    idle(1, 0);
    check_eq("adel_pc", seen_pc.size() == 1 ? seen_pc[0] : 32'hX, 32'hBFC0_0382);
    check_eq("adel_flag", seen_adel.size() == 1 ? 32'(seen_adel[0]) : 32'hX, 32'd1);
    idle(1, 0);
    cyc(0, 0, 32'h0, 1, 32'hBFC0_0500, 1, 0);
    cyc(0, 1, 32'hBFC0_0380, 0, 32'h0, 0, 0);
    idle(1, 0);
    check_eq("err_issue", seen_issue.size() == 1 ? seen_issue[0] : 32'hX, 32'hBFC0_0380);
    idle(0, 1);

    // asynchronous reset in WAIT with a stale data_ok
    clear_seen();
    idle(1, 0);
    do_reset(1);
    idle(1, 0);
    check_eq("rst_restart", seen_issue.size() == 2 ? seen_issue[1] : 32'hX, 32'hBFC0_0000);
    check_eq("rst_no_stale", seen_pc.size(), 0);
    idle(0, 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 99) < 3);
      b = ($urandom_range(0, 99) < 8);
      a = ($urandom_range(0, 9) < 6);
      d = m_fly && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 599) == 0) do_reset(d);
      else cyc(s, f, rand_tgt(20), b, rand_tgt(5), a, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
